// File: rtl/fifo_block_reducer.sv
// Block reducer: sums cfg_block_len words (or up to in_last) into one result per block.
// Optional macro FIFO_REDUCER_SAT_EN makes the per-block sum saturate instead of wrap.
module fifo_block_reducer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              pcie_clk,
  input  logic              pcie_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  cfg_block_len,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  blocks_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_len;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_blocks;

  logic              w_in_acc;
  logic              w_out_acc;
  logic [CNT_W-1:0]  w_len_eff;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W:0]   w_sum_ext;
  logic              w_carry;
  logic [DATA_W-1:0] w_acc_nxt;

  assign w_len_eff = (cfg_block_len == '0) ? CNT_W'(1) : cfg_block_len;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_sum_ext = {1'b0, r_acc} + {1'b0, in_data};
  assign w_carry   = w_sum_ext[DATA_W];

`ifdef FIFO_REDUCER_SAT_EN
  // Once saturated the accumulator is pinned; adding zero would otherwise not carry.
  assign w_acc_nxt = (w_carry || r_ovf) ? '1 : w_sum_ext[DATA_W-1:0];
`else
  assign w_acc_nxt = w_sum_ext[DATA_W-1:0];
`endif

  // in_ready is forced low while reset is asserted so nothing is taken that cycle.
  assign in_ready  = (r_state != S_HOLD) && !pcie_rst;
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;

  assign out_sum     = r_acc;
  assign out_count   = r_cnt;
  assign out_ovf     = r_ovf;
  assign blocks_done = r_blocks;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_acc) begin
          if (w_len_eff == CNT_W'(1) || in_last) w_state_nxt = S_HOLD;
          else                                   w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (w_in_acc && (w_cnt_inc == r_len || in_last)) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_out_acc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_len    <= CNT_W'(1);
      r_ovf    <= 1'b0;
      r_blocks <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_in_acc) begin
            r_acc <= in_data;
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
            r_len <= w_len_eff;
          end
        end
        S_ACC: begin
          if (w_in_acc) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_carry;
          end
        end
        S_HOLD: begin
          if (w_out_acc) r_blocks <= r_blocks + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_block_reducer.sv
// Directed bench for fifo_block_reducer with a result scoreboard.
module tb_fifo_block_reducer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              pcie_clk = 1'b0;
  logic              pcie_rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [CNT_W-1:0]  cfg_block_len;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  blocks_done;

  typedef struct {
    logic [DATA_W-1:0] sum;
    logic [CNT_W-1:0]  count;
    logic              ovf;
  } result_t;

  result_t sb[$];
  int checks   = 0;
  int failures = 0;

  fifo_block_reducer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .pcie_clk      (pcie_clk),
    .pcie_rst      (pcie_rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .cfg_block_len (cfg_block_len),
    .out_sum       (out_sum),
    .out_count     (out_count),
    .out_ovf       (out_ovf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .blocks_done   (blocks_done)
  );

  always #5 pcie_clk = ~pcie_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] s, input logic [CNT_W-1:0] c, input logic o);
    result_t r;
    r.sum = s; r.count = c; r.ovf = o;
    sb.push_back(r);
  endtask

  // Holds the word until accepted; leaves in_valid high for back-to-back sends.
  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    int unsigned waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    step();
  endtask

  always @(negedge pcie_clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = sb.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_count", 32'(out_count), 32'(e.count));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    pcie_rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    cfg_block_len = 16'd4; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_blocks", 32'(blocks_done), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    pcie_rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // len 4, back-to-back
    push(32'd10, 16'd4, 1'b0);
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b0);
    in_valid = 1'b0;
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_blocks", 32'(blocks_done), 32'd1);

    // early close with in_last, then restart at count 1
    cfg_block_len = 16'd8;
    push(32'd12, 16'd2, 1'b0);
    send(32'd5, 1'b0); send(32'd7, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t2_valid", 32'(out_valid), 32'd1);
    step();
    push(32'd3, 16'd1, 1'b0);
    send(32'd3, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t2b_valid", 32'(out_valid), 32'd1);
    step();
    chk("t2_blocks", 32'(blocks_done), 32'd3);

    // carry out
    cfg_block_len = 16'd2;
`ifdef FIFO_REDUCER_SAT_EN
    push(32'hFFFF_FFFF, 16'd2, 1'b1);
`else
    push(32'h0000_0001, 16'd2, 1'b1);
`endif
    send(32'hFFFF_FFFF, 1'b0); send(32'h0000_0002, 1'b0);
    in_valid = 1'b0;
    step();
    chk("t3_blocks", 32'(blocks_done), 32'd4);

    // len 0 behaves as 1
    cfg_block_len = 16'd0;
    push(32'd9, 16'd1, 1'b0);
    push(32'd11, 16'd1, 1'b0);
    send(32'd9, 1'b0);
    chk("t4_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("t4_ready_back", 32'(in_ready), 32'd1);
    send(32'd11, 1'b0);
    in_valid = 1'b0;
    chk("t4_ready_low2", 32'(in_ready), 32'd0);
    step();
    chk("t4_ready_back2", 32'(in_ready), 32'd1);
    chk("t4_blocks", 32'(blocks_done), 32'd6);

    // backpressure on the result
    cfg_block_len = 16'd3;
    out_ready = 1'b0;
    push(32'd6, 16'd3, 1'b0);
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_in_ready", 32'(in_ready), 32'd0);
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_sum_stable", out_sum, 32'd6);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t5_blocks", 32'(blocks_done), 32'd7);
    chk("t5_in_ready_after", 32'(in_ready), 32'd1);

    // reset mid-block discards the partial block
    cfg_block_len = 16'd4;
    send(32'd1, 1'b0); send(32'd2, 1'b0);
    in_valid = 1'b0;
    chk("t6_busy_mid", 32'(busy), 32'd1);
    pcie_rst = 1'b1;
    step();
    pcie_rst = 1'b0;
    #1;
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    chk("t6_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t6_blocks_after_rst", 32'(blocks_done), 32'd0);
    push(32'd100, 16'd4, 1'b0);
    send(32'd10, 1'b0); send(32'd20, 1'b0); send(32'd30, 1'b0); send(32'd40, 1'b0);
    in_valid = 1'b0;
    step();
    repeat (3) step();
    chk("t6_blocks", 32'(blocks_done), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
